// File: rtl/ras_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : ras_predictor
//  Description : Return-address stack that predicts JALR targets for the
//                PC controller.
//                - Pushes on calls and pops on returns.
//                - Exports a checkpoint {ptr, count, top} for the backend.
//                - Restores from a checkpoint on misprediction.
//                Optional macro RAS_TMR_EN triplicates the pointer and the
//                occupancy with majority voting and fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  cf_valid_i,
    input  logic                  cf_is_call_i,
    input  logic                  cf_is_ret_i,
    input  logic [DATA_WIDTH-1:0] cf_ret_addr_i,
    output logic                  pred_valid_o,
    output logic [DATA_WIDTH-1:0] pred_target_o,
    output logic [PTR_W-1:0]      ckpt_ptr_o,
    output logic [PTR_W:0]        ckpt_count_o,
    output logic [DATA_WIDTH-1:0] ckpt_top_o,
    input  logic                  misprediction_i,
    input  logic [PTR_W-1:0]      restore_ptr_i,
    input  logic [PTR_W:0]        restore_count_i,
    input  logic [DATA_WIDTH-1:0] restore_top_i,
    output logic                  fatal_o
);

    // Full-stack occupancy expressed in the count width.
    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] stack_q [DEPTH];

    // Effective (voted when triplicated) pointer and occupancy.
    logic [PTR_W-1:0]      ptr_v;
    logic [PTR_W:0]        count_v;

    logic [PTR_W-1:0]      ptr_d;
    logic [PTR_W:0]        count_d;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

`ifdef RAS_TMR_EN
    logic [2:0][PTR_W-1:0] tos_ptr_q;
    logic [2:0][PTR_W:0]   count_q;

    assign ptr_v   = (tos_ptr_q[0] & tos_ptr_q[1]) | (tos_ptr_q[0] & tos_ptr_q[2])
                   | (tos_ptr_q[1] & tos_ptr_q[2]);
    assign count_v = (count_q[0] & count_q[1]) | (count_q[0] & count_q[2])
                   | (count_q[1] & count_q[2]);

    // All three copies of a field disagreeing pairwise cannot be outvoted.
    assign fatal_o = ((tos_ptr_q[0] != tos_ptr_q[1]) && (tos_ptr_q[0] != tos_ptr_q[2])
                      && (tos_ptr_q[1] != tos_ptr_q[2]))
                  || ((count_q[0] != count_q[1]) && (count_q[0] != count_q[2])
                      && (count_q[1] != count_q[2]));

    // Every replica is rewritten every cycle so a single upset heals at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            tos_ptr_q <= {3{ptr_d}};
            count_q   <= {3{count_d}};
        end
    end
`else
    logic [PTR_W-1:0] tos_ptr_q;
    logic [PTR_W:0]   count_q;

    assign ptr_v   = tos_ptr_q;
    assign count_v = count_q;
    assign fatal_o = 1'b0;

    // Single-copy pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            tos_ptr_q <= ptr_d;
            count_q   <= count_d;
        end
    end
`endif

    // Next-state selection.
    // Priority: restore, then stall/idle, then call&ret, then call, then ret.
    always_comb begin
        ptr_d   = ptr_v;
        count_d = count_v;
        wr_en   = 1'b0;
        wr_idx  = ptr_v;
        wr_data = cf_ret_addr_i;
        if (misprediction_i) begin
            wr_en   = 1'b1;
            wr_idx  = restore_ptr_i;
            wr_data = restore_top_i;
            ptr_d   = restore_ptr_i;
            count_d = (restore_count_i > c_DEPTH_CNT) ? c_DEPTH_CNT : restore_count_i;
        end else if (!stall_i && cf_valid_i) begin
            if (cf_is_call_i && cf_is_ret_i) begin
                // Pop then push lands on the same slot: replace the top.
                wr_en = 1'b1;
            end else if (cf_is_call_i) begin
                // A push on a full stack wraps and overwrites the oldest entry.
                ptr_d   = ptr_v + PTR_W'(1);
                wr_en   = 1'b1;
                wr_idx  = ptr_v + PTR_W'(1);
                count_d = (count_v == c_DEPTH_CNT) ? count_v : count_v + (PTR_W + 1)'(1);
            end else if (cf_is_ret_i && (count_v != '0)) begin
                // Popped entries are left in place; a later restore may re-expose them.
                ptr_d   = ptr_v - PTR_W'(1);
                count_d = count_v - (PTR_W + 1)'(1);
            end
        end
    end

    // Entry storage: cleared on reset, a single write port otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

    assign pred_valid_o  = (count_v != '0);
    assign pred_target_o = stack_q[ptr_v];
    assign ckpt_ptr_o    = ptr_v;
    assign ckpt_count_o  = count_v;
    assign ckpt_top_o    = stack_q[ptr_v];

endmodule
`default_nettype wire
